// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiply-accumulate: product = A*B + C, one multiplier bit per cycle.
// Fixed 16-cycle RUN phase; requests arriving while busy are dropped, not queued.
module shift_add_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [15:0] multiplier,
  input  logic [15:0] addend,
  output logic [47:0] product,
  output logic        done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_a;
  logic [31:0] w_a_nxt;
  logic [15:0] r_b;
  logic [15:0] w_b_nxt;
  logic [47:0] r_acc;
  logic [47:0] w_acc_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [47:0] r_product;
  logic [47:0] w_product_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_busy;
  logic        w_busy_nxt;

  logic [47:0] w_partial;
  logic [47:0] w_sum;

  // Shifted multiplicand for the current bit; zero when that multiplier bit is clear.
  assign w_partial = r_b[r_cnt] ? ({16'b0, r_a} << r_cnt) : 48'b0;
  assign w_sum     = r_acc + w_partial;

  always_comb begin
    w_state_nxt   = r_state;
    w_a_nxt       = r_a;
    w_b_nxt       = r_b;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    w_done_nxt    = 1'b0;
    w_busy_nxt    = r_busy;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_a_nxt     = multiplicand;
          w_b_nxt     = multiplier;
          w_acc_nxt   = {32'b0, addend};
          w_cnt_nxt   = 4'd0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        // start is deliberately not examined here, so in-flight operands stay untouched.
        w_acc_nxt = w_sum;
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          w_product_nxt = w_sum;
          w_done_nxt    = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = S_DONE;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_a       <= 32'b0;
      r_b       <= 16'b0;
      r_acc     <= 48'b0;
      r_cnt     <= 4'd0;
      r_product <= 48'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign product = r_product;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 start  input  1  request pulse; accepted only when busy=0.
REQ-005 multiplicand  input  32  unsigned operand A; sampled on the accepting edge.
REQ-006 multiplier  input  16  unsigned operand B; sampled on the accepting edge.
REQ-007 addend  input  16  unsigned offset C; sampled on the accepting edge.
REQ-008 product  output  48  registered result A*B+C; held stable between completions.
REQ-009 done  output  1  registered one-cycle completion pulse.
REQ-010 busy  output  1  registered; high while an operation is in progress.

Function
REQ-011 Block SHALL reconstruct the dividend from a quotient/divisor/remainder triple: product = multiplicand*multiplier + addend, unsigned.
REQ-012 State machine SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE/DONE + start=1 -> latch A, B, C; accumulator := {32'b0, C}; bit counter := 0; go to RUN; busy := 1.
REQ-014 IDLE + start=0 -> stay IDLE; DONE + start=0 -> IDLE.
REQ-015 RUN: each cycle, if B[counter]=1 then accumulator += (A << counter), 48-bit add; counter += 1.
REQ-016 RUN SHALL last exactly 16 cycles (counter 0..15), independent of operand values; no early termination.
REQ-017 On the edge processing counter=15: product := final accumulator, done := 1, busy := 0, go to DONE.
REQ-018 Latency: start sampled at edge k -> done=1 and product valid after edge k+16; done high for exactly one cycle.
REQ-019 start while busy=1 SHALL be ignored; operands and operation in flight unaffected.
REQ-020 start high in DONE (back-to-back) SHALL be accepted; done drops to 0 on that edge.
REQ-021 product SHALL change only on the completion edge and on reset; it holds the last result otherwise, including while a new operation runs.
REQ-022 Accumulator and product SHALL be 48 bits; no overflow possible (max result 0xFFFF_0000_0000); no truncation permitted.
REQ-023 Operand input changes after the accepting edge SHALL NOT affect the result.
REQ-024 B=0 SHALL yield product=C after the full 16-cycle latency; A=0 likewise.

Reset
REQ-025 rst=0 at a rising edge -> state IDLE, product=0, done=0, busy=0, accumulator=0, counter=0.
REQ-026 Reset SHALL take priority over start and over any in-progress operation (RUN or DONE); aborted operation produces no done pulse.
REQ-027 start high in the same cycle as rst=0 SHALL be ignored; first accept possible on the first edge with rst=1.

Verification
REQ-028 A=17, B=2, C=1 -> product=35, done pulse exactly 16 cycles after start edge, busy high 16 cycles.
REQ-029 Sequential cases: (33,3,1)->100; (257,255,0)->65535; (10,123,4)->1234; (0,7,0)->0; (0,16,7)->7.
REQ-030 A=0xFFFFFFFF, B=0xFFFF, C=0xFFFF -> product=0xFFFF_0000_0000.
REQ-031 Start (5,5,0) then pulse start with (9,9,9) at cycle 4 of RUN -> product=25, second request ignored, one done pulse.
REQ-032 Start (100,100,0), assert rst=0 at RUN cycle 8 -> product=0, busy=0, no done; subsequent (6,7,2) -> 44.
REQ-033 Back-to-back: start (3,4,0) re-asserted in DONE cycle with (5,6,1) -> product 12 then 31, two done pulses 17 cycles apart.
